// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_pkg
// Description : Shared types and the rename-to-ROB packet for the ROB slice.
// Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int NUM_ROB_ENTRY = 32;
    localparam int NUM_PHYREG    = 128;
    localparam int NUM_ARCHREG   = 32;

    localparam int ROB_IDX_W  = $clog2(NUM_ROB_ENTRY);
    localparam int ROB_CNT_W  = ROB_IDX_W + 1;
    localparam int PHY_ID_W   = $clog2(NUM_PHYREG);
    localparam int ARCH_ID_W  = $clog2(NUM_ARCHREG);

    typedef logic [ROB_IDX_W-1:0] RobIndex_T;
    typedef logic [ROB_CNT_W-1:0] RobCount_T;
    typedef logic [PHY_ID_W-1:0]  PhyRegisterId_T;
    typedef logic [ARCH_ID_W-1:0] ArchRegisterId_T;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            exc;
        logic            hasDst;
        ArchRegisterId_T archDst;
        PhyRegisterId_T  phyDst;
        PhyRegisterId_T  prevPhy;
    } RobEntry_T;

    // Layout matches what the rename unit emits per instruction
    typedef struct packed {
        logic            hasDst;
        ArchRegisterId_T archDst;
        PhyRegisterId_T  phyDst;
        PhyRegisterId_T  prevPhy;
    } RruToRob;

    function automatic RruToRob RruToRobEncap(
        input logic            hasDst,
        input ArchRegisterId_T archDst,
        input PhyRegisterId_T  phyDst,
        input PhyRegisterId_T  prevPhy
    );
        RruToRob pkt;
        pkt.hasDst  = hasDst;
        pkt.archDst = archDst;
        pkt.phyDst  = phyDst;
        pkt.prevPhy = prevPhy;
        return pkt;
    endfunction

    function automatic RobEntry_T RruToRobDecap(input RruToRob pkt);
        RobEntry_T entry;
        entry.valid   = 1'b1;
        entry.done    = 1'b0;
        entry.exc     = 1'b0;
        entry.hasDst  = pkt.hasDst;
        entry.archDst = pkt.archDst;
        entry.phyDst  = pkt.phyDst;
        entry.prevPhy = pkt.prevPhy;
        return entry;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Dispatch, completion and retire signals of the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic            dispValid;
    logic            dispReady;
    logic            dispHasDst;
    ArchRegisterId_T dispArchDst;
    PhyRegisterId_T  dispPhyDst;
    PhyRegisterId_T  dispPrevPhy;
    RobIndex_T       robTailIdx;

    logic            cmplValid;
    RobIndex_T       cmplRobIdx;
    logic            cmplExc;

    logic            commitValid;
    logic            commitHasDst;
    ArchRegisterId_T commitArchDst;
    PhyRegisterId_T  commitPhyDst;
    PhyRegisterId_T  commitFreePhy;
    logic            flushOut;
    logic            robEmpty;
    logic            robFull;

    modport master (
        output dispValid, dispHasDst, dispArchDst, dispPhyDst, dispPrevPhy,
        output cmplValid, cmplRobIdx, cmplExc,
        input  dispReady, robTailIdx,
        input  commitValid, commitHasDst, commitArchDst, commitPhyDst, commitFreePhy,
        input  flushOut, robEmpty, robFull
    );

    modport slave (
        input  dispValid, dispHasDst, dispArchDst, dispPhyDst, dispPrevPhy,
        input  cmplValid, cmplRobIdx, cmplExc,
        output dispReady, robTailIdx,
        output commitValid, commitHasDst, commitArchDst, commitPhyDst, commitFreePhy,
        output flushOut, robEmpty, robFull
    );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_ptr_ctrl
// Description : Head/tail/occupancy bookkeeping for the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr_ctrl #(
    parameter int NUM_ENTRY = 32,
    localparam int IDX_W    = $clog2(NUM_ENTRY),
    localparam int CNT_W    = IDX_W + 1
) (
    input  wire  logic             clk,
    input  wire  logic             rst,
    input  wire  logic             i_push,
    input  wire  logic             i_pop,
    input  wire  logic             i_flush,
    output logic       [IDX_W-1:0] o_head,
    output logic       [IDX_W-1:0] o_tail,
    output logic       [CNT_W-1:0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam logic [CNT_W-1:0] c_fullCount = CNT_W'(NUM_ENTRY);

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // Power-of-two depth: pointers wrap naturally without an extra lap bit
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + IDX_W'(1);
            if (i_pop)  r_head <= r_head + IDX_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_count;
    assign o_full  = (r_count == c_fullCount);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement buffer downstream of register renaming.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input wire logic         SIG_CLK,
    input wire logic         SIG_RST,
    reorder_buffer_if.slave  robIf
);

    RobEntry_T       r_entries [NUM_ROB_ENTRY];
    logic            r_commitValid;
    logic            r_commitHasDst;
    ArchRegisterId_T r_commitArchDst;
    PhyRegisterId_T  r_commitPhyDst;
    PhyRegisterId_T  r_commitFreePhy;
    logic            r_flushOut;

    RobIndex_T       w_head;
    RobIndex_T       w_tail;
    RobCount_T       w_count;
    logic            w_full;
    logic            w_empty;
    RobEntry_T       w_headEntry;
    RobEntry_T       w_dispEntry;
    logic            w_commit;
    logic            w_flushPending;
    logic            w_dispReady;
    logic            w_dispAccept;

    rob_ptr_ctrl #(
        .NUM_ENTRY (NUM_ROB_ENTRY)
    ) u_ptrCtrl (
        .clk     (SIG_CLK),
        .rst     (SIG_RST),
        .i_push  (w_dispAccept),
        .i_pop   (w_commit),
        .i_flush (w_flushPending),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_headEntry    = r_entries[w_head];
    assign w_commit       = w_headEntry.valid && w_headEntry.done && !w_headEntry.exc;
    assign w_flushPending = w_headEntry.valid && w_headEntry.done &&  w_headEntry.exc;
    assign w_dispReady    = !SIG_RST && !w_full && !w_flushPending;
    assign w_dispAccept   = robIf.dispValid && w_dispReady;
    assign w_dispEntry    = RruToRobDecap(RruToRobEncap(robIf.dispHasDst, robIf.dispArchDst,
                                                        robIf.dispPhyDst, robIf.dispPrevPhy));

    // Completion first, then retire, then dispatch: dispatch never targets the
    // head slot while it retires because a full buffer refuses dispatch.
    always_ff @(posedge SIG_CLK) begin
        if (SIG_RST || w_flushPending) begin
            for (int i = 0; i < NUM_ROB_ENTRY; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (robIf.cmplValid && r_entries[robIf.cmplRobIdx].valid) begin
                r_entries[robIf.cmplRobIdx].done <= 1'b1;
                r_entries[robIf.cmplRobIdx].exc  <= robIf.cmplExc;
            end
            if (w_commit) begin
                r_entries[w_head].valid <= 1'b0;
            end
            if (w_dispAccept) begin
                r_entries[w_tail] <= w_dispEntry;
            end
        end
    end

    always_ff @(posedge SIG_CLK) begin
        if (SIG_RST) begin
            r_commitValid   <= 1'b0;
            r_commitHasDst  <= 1'b0;
            r_commitArchDst <= '0;
            r_commitPhyDst  <= '0;
            r_commitFreePhy <= '0;
            r_flushOut      <= 1'b0;
        end else begin
            r_commitValid <= w_commit;
            r_flushOut    <= w_flushPending;
            if (w_commit) begin
                r_commitHasDst  <= w_headEntry.hasDst;
                r_commitArchDst <= w_headEntry.archDst;
                r_commitPhyDst  <= w_headEntry.phyDst;
                r_commitFreePhy <= w_headEntry.prevPhy;
            end
        end
    end

    assign robIf.dispReady     = w_dispReady;
    assign robIf.robTailIdx    = w_tail;
    assign robIf.commitValid   = r_commitValid;
    assign robIf.commitHasDst  = r_commitHasDst;
    assign robIf.commitArchDst = r_commitArchDst;
    assign robIf.commitPhyDst  = r_commitPhyDst;
    assign robIf.commitFreePhy = r_commitFreePhy;
    assign robIf.flushOut      = r_flushOut;
    assign robIf.robEmpty      = w_empty;
    assign robIf.robFull       = w_full;

    logic w_unusedCount;
    assign w_unusedCount = ^w_count;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed scoreboard bench for reorder_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk;
    logic rst;
    int   testCount = 0;
    int   failCount = 0;

    reorder_buffer_if robIf ();

    reorder_buffer dut (
        .SIG_CLK (clk),
        .SIG_RST (rst),
        .robIf   (robIf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    bit      mValid [NUM_ROB_ENTRY];
    bit      mDone  [NUM_ROB_ENTRY];
    bit      mExc   [NUM_ROB_ENTRY];
    int      mHead, mTail, mCount;
    RruToRob expQ [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < NUM_ROB_ENTRY; i++) begin
            mValid[i] = 0;
            mDone[i]  = 0;
            mExc[i]   = 0;
        end
        mHead  = 0;
        mTail  = 0;
        mCount = 0;
        expQ.delete();
    endtask

    // One clock: predict, advance, compare against the model
    task automatic tick();
        bit      expCommit, expFlush, mReady, accDisp;
        RruToRob pkt, exp;
        int      ci;
        #1;
        expCommit = mValid[mHead] && mDone[mHead] && !mExc[mHead];
        expFlush  = mValid[mHead] && mDone[mHead] &&  mExc[mHead];
        mReady    = !rst && (mCount < NUM_ROB_ENTRY) && !expFlush;
        accDisp   = robIf.dispValid && mReady;
        pkt.hasDst  = robIf.dispHasDst;
        pkt.archDst = robIf.dispArchDst;
        pkt.phyDst  = robIf.dispPhyDst;
        pkt.prevPhy = robIf.dispPrevPhy;
        check("dispReady", 32'(robIf.dispReady), 32'(mReady));
        @(posedge clk);
        #1;
        if (rst) begin
            modelClear();
            check("rstCommitValid", 32'(robIf.commitValid), 0);
            check("rstFlushOut", 32'(robIf.flushOut), 0);
            check("rstFreePhy", 32'(robIf.commitFreePhy), 0);
        end else begin
            check("commitValid", 32'(robIf.commitValid), 32'(expCommit));
            check("flushOut", 32'(robIf.flushOut), 32'(expFlush));
            if (expFlush) begin
                modelClear();
            end else begin
                ci = int'(robIf.cmplRobIdx);
                if (robIf.cmplValid && mValid[ci]) begin
                    mDone[ci] = 1;
                    mExc[ci]  = robIf.cmplExc;
                end
                if (expCommit && expQ.size() > 0) begin
                    exp = expQ.pop_front();
                    check("commitFreePhy", 32'(robIf.commitFreePhy), 32'(exp.prevPhy));
                    check("commitPhyDst", 32'(robIf.commitPhyDst), 32'(exp.phyDst));
                    check("commitArchDst", 32'(robIf.commitArchDst), 32'(exp.archDst));
                    check("commitHasDst", 32'(robIf.commitHasDst), 32'(exp.hasDst));
                    mValid[mHead] = 0;
                    mHead = (mHead + 1) % NUM_ROB_ENTRY;
                end
                if (accDisp) begin
                    mValid[mTail] = 1;
                    mDone[mTail]  = 0;
                    mExc[mTail]   = 0;
                    expQ.push_back(pkt);
                    mTail = (mTail + 1) % NUM_ROB_ENTRY;
                end
                mCount = mCount + int'(accDisp) - int'(expCommit);
            end
        end
        check("robEmpty", 32'(robIf.robEmpty), 32'(mCount == 0));
        check("robFull", 32'(robIf.robFull), 32'(mCount == NUM_ROB_ENTRY));
        check("robTailIdx", 32'(robIf.robTailIdx), 32'(mTail));
    endtask

    task automatic dispatch(input logic hasDst, input int arch, input int phy, input int prev);
        robIf.dispValid   = 1'b1;
        robIf.dispHasDst  = hasDst;
        robIf.dispArchDst = ArchRegisterId_T'(arch);
        robIf.dispPhyDst  = PhyRegisterId_T'(phy);
        robIf.dispPrevPhy = PhyRegisterId_T'(prev);
        tick();
        robIf.dispValid   = 1'b0;
    endtask

    task automatic complete(input int idx, input logic exc);
        robIf.cmplValid  = 1'b1;
        robIf.cmplRobIdx = RobIndex_T'(idx);
        robIf.cmplExc    = exc;
        tick();
        robIf.cmplValid  = 1'b0;
        robIf.cmplExc    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int base;
        modelClear();
        rst = 1'b1;
        robIf.dispValid   = 1'b0;
        robIf.dispHasDst  = 1'b0;
        robIf.dispArchDst = '0;
        robIf.dispPhyDst  = '0;
        robIf.dispPrevPhy = '0;
        robIf.cmplValid   = 1'b0;
        robIf.cmplRobIdx  = '0;
        robIf.cmplExc     = 1'b0;
        idle(2);
        check("resetTail", 32'(robIf.robTailIdx), 0);
        check("resetEmpty", 32'(robIf.robEmpty), 1);
        rst = 1'b0;

        // In-order completion retires on consecutive cycles, freeing 1..4
        for (int i = 0; i < 4; i++) dispatch(1'b1, i + 1, 40 + i, 1 + i);
        for (int i = 0; i < 4; i++) complete(i, 1'b0);
        idle(1);
        check("t1Empty", 32'(robIf.robEmpty), 1);

        // Reverse-order completion: nothing retires until the oldest is done
        base = mTail;
        for (int i = 0; i < 3; i++) dispatch(1'b1, 10 + i, 60 + i, 20 + i);
        complete((base + 2) % NUM_ROB_ENTRY, 1'b0);
        complete((base + 1) % NUM_ROB_ENTRY, 1'b0);
        idle(2);
        check("t2NoCommit", 32'(robIf.commitValid), 0);
        complete(base, 1'b0);
        idle(4);
        check("t2Empty", 32'(robIf.robEmpty), 1);

        // Exception at the head flushes and rewinds the pointers
        for (int i = 0; i < 3; i++) dispatch(1'b0, 0, 70 + i, 30 + i);
        complete(mHead, 1'b1);
        idle(1);
        idle(1);
        check("t4Empty", 32'(robIf.robEmpty), 1);
        check("t4Tail", 32'(robIf.robTailIdx), 0);

        // Fill to capacity, refused 33rd dispatch, wrap of the tail
        for (int i = 0; i < NUM_ROB_ENTRY; i++) dispatch(1'b1, i, i + 1, 127 - i);
        check("t3Full", 32'(robIf.robFull), 1);
        check("t3Ready", 32'(robIf.dispReady), 0);
        dispatch(1'b1, 5, 99, 98);
        check("t3TailHeld", 32'(robIf.robTailIdx), 0);
        complete(0, 1'b0);
        idle(1);
        check("t3NotFull", 32'(robIf.robFull), 0);
        dispatch(1'b0, 3, 88, 77);
        check("t3TailAfter", 32'(robIf.robTailIdx), 1);
        for (int i = 1; i < NUM_ROB_ENTRY; i++) complete(i, 1'b0);
        complete(0, 1'b0);
        idle(2);
        check("t3Drained", 32'(robIf.robEmpty), 1);

        // Completion aimed at an unoccupied slot is ignored
        base = mTail;
        for (int i = 0; i < 3; i++) dispatch(1'b1, 4, 90 + i, 50 + i);
        complete((base + 6) % NUM_ROB_ENTRY, 1'b0);
        idle(3);
        check("t5NoCommit", 32'(robIf.commitValid), 0);
        for (int i = 0; i < 3; i++) complete((base + i) % NUM_ROB_ENTRY, 1'b0);
        idle(2);

        // Reset with work pending discards everything silently
        for (int i = 0; i < 5; i++) dispatch(1'b1, i, 100 + i, 110 + i);
        complete(mHead, 1'b0);
        rst = 1'b1;
        tick();
        check("t6Tail", 32'(robIf.robTailIdx), 0);
        check("t6Empty", 32'(robIf.robEmpty), 1);
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
